// File: rtl/uart_tx_arbiter.sv
// Arbitrates NUM_REQ byte producers onto one UART transmitter and sequences its start/busy handshake.
// Define UART_ARB_RR_EN for round-robin arbitration; the default build uses fixed lowest-index priority.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned IDW           = 2,
    parameter int unsigned START_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 cfg_par_en,
    input  logic                 cfg_par_typ,
    output logic [7:0]           P_DATA,
    output logic                 DATA_VALID,
    output logic                 PAR_EN,
    output logic                 PAR_TYP,
    input  logic                 BUSY,
    output logic [IDW-1:0]       grant_id,
    output logic                 arb_busy,
    output logic                 start_err,
    output logic [15:0]          frame_cnt
);

    localparam int unsigned CntW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StWaitStart, StWaitDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      data_q, data_d;
    logic            par_en_q, par_en_d;
    logic            par_typ_q, par_typ_d;
    logic [IDW-1:0]  gid_q, gid_d;
    logic            err_q, err_d;
    logic [15:0]     frame_q, frame_d;

    logic            win_vld;
    logic [IDW-1:0]  win_idx;
    logic [NUM_REQ-1:0] win_oh;

`ifdef UART_ARB_RR_EN
    logic [IDW-1:0]  rr_q, rr_d;
    logic [2*NUM_REQ-1:0] rot;
    logic [IDW:0]    sum;

    // Rotate so the pointer position sits at bit 0, then take the lowest set bit.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        sum     = '0;
        rot     = {req_valid, req_valid} >> rr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_vld && rot[k]) begin
                win_vld = 1'b1;
                sum     = {1'b0, rr_q} + (IDW+1)'(k);
                if (sum >= (IDW+1)'(NUM_REQ)) begin
                    sum = sum - (IDW+1)'(NUM_REQ);
                end
                win_idx = sum[IDW-1:0];
            end
        end
    end
`else
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_vld && req_valid[k]) begin
                win_vld = 1'b1;
                win_idx = IDW'(k);
            end
        end
    end
`endif

    assign win_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        gid_d     = gid_q;
        err_d     = 1'b0;
        frame_d   = frame_q;
        req_ready = '0;
`ifdef UART_ARB_RR_EN
        rr_d      = rr_q;
`endif
        case (state_q)
            StIdle: begin
                if (!rst && !BUSY && win_vld) begin
                    req_ready = win_oh;
                    data_d    = req_data[8*win_idx +: 8];
                    par_en_d  = cfg_par_en;
                    par_typ_d = cfg_par_typ;
                    gid_d     = win_idx;
                    state_d   = StLoad;
`ifdef UART_ARB_RR_EN
                    rr_d      = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StWaitStart;
            end
            StWaitStart: begin
                // BUSY on the last permitted cycle still wins over the timeout.
                if (BUSY) begin
                    state_d = StWaitDone;
                end else if (cnt_q == CntW'(START_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!BUSY) begin
                    frame_d = frame_q + 16'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            data_q    <= 8'h00;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            gid_q     <= '0;
            err_q     <= 1'b0;
            frame_q   <= 16'h0000;
`ifdef UART_ARB_RR_EN
            rr_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            gid_q     <= gid_d;
            err_q     <= err_d;
            frame_q   <= frame_d;
`ifdef UART_ARB_RR_EN
            rr_q      <= rr_d;
`endif
        end
    end

    assign P_DATA     = data_q;
    assign PAR_EN     = par_en_q;
    assign PAR_TYP    = par_typ_q;
    assign grant_id   = gid_q;
    assign start_err  = err_q;
    assign frame_cnt  = frame_q;
    assign DATA_VALID = (state_q == StLoad);
    assign arb_busy   = (state_q != StIdle);

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single UART transmitter (`tx`) between `NUM_REQ` byte producers. It grants one requester at a time and latches that requester's byte and the parity configuration. It then pulses `DATA_VALID` into the transmitter and tracks `BUSY` until the frame completes. The block sits between the system-side producers and the `tx` instance and is the only driver of that instance's `P_DATA`, `DATA_VALID`, `PAR_EN` and `PAR_TYP` inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `IDW`, 2: grant index width, must equal ceil(log2(`NUM_REQ`)).
- `START_TIMEOUT`, 4: maximum cycles spent in WAIT_START waiting for `BUSY` to rise.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous reset, active-high.
- `req_valid` in `NUM_REQ`: per-requester byte available.
- `req_data` in 8*`NUM_REQ`: byte i is bits [8i+7:8i].
- `req_ready` out `NUM_REQ`: one-hot accept; a transfer occurs on an edge where valid and ready are both 1.
- `cfg_par_en` in 1: parity enable, sampled at accept.
- `cfg_par_typ` in 1: parity type (0 = even, 1 = odd), sampled at accept.
- `P_DATA` out 8: byte to `tx`.
- `DATA_VALID` out 1: one-cycle start strobe to `tx`.
- `PAR_EN` out 1: to `tx`.
- `PAR_TYP` out 1: to `tx`.
- `BUSY` in 1: from `tx`.
- `grant_id` out `IDW`: index of the last accepted requester.
- `arb_busy` out 1: high whenever the FSM is not in IDLE.
- `start_err` out 1: one-cycle pulse on start timeout.
- `frame_cnt` out 16: count of completed frames, wraps at 0xFFFF→0.

## Operation
- FSM states: IDLE, LOAD, WAIT_START, WAIT_DONE.
- IDLE: `req_ready` = one-hot of the arbitration winner, gated by `BUSY`=0. It is combinational and all-zero when no `req_valid` is set, while `rst`=1, or in any other state.
- On transfer, at the same edge:
  - `P_DATA` ← the winner's byte; `PAR_EN` ← `cfg_par_en`; `PAR_TYP` ← `cfg_par_typ`.
  - `grant_id` ← winner.
  - Move to LOAD.
- LOAD:
  - `DATA_VALID` is 1 for exactly this cycle.
  - Next state is WAIT_START; the timeout counter is cleared.
- WAIT_START:
  - `BUSY`=1 → WAIT_DONE.
  - Otherwise the counter increments.
  - When the counter reaches `START_TIMEOUT`: pulse `start_err`, return to IDLE, leave `frame_cnt` unchanged.
- WAIT_DONE:
  - `BUSY`=0 → IDLE and `frame_cnt` += 1.
- Register hold rules:
  - `P_DATA`, `PAR_EN` and `PAR_TYP` are held constant from accept until the next accept, so the configuration is stable for the whole frame.
  - `cfg_*` changes after accept have no effect on the current frame.
- `req_valid` dropped by a requester before it is accepted: no transfer occurs; the arbiter re-evaluates in the next cycle.
- Reset, at any state including mid-frame:
  - Next state is IDLE.
  - `P_DATA`=0x00; `DATA_VALID`, `PAR_EN`, `PAR_TYP`, `arb_busy` and `start_err` are 0.
  - `grant_id`=0, `frame_cnt`=0, round-robin pointer=0.
  - A frame already inside `tx` is not aborted by this block.

## Timing
- Accept edge N, then:
  - `DATA_VALID`=1 during cycle N+1.
  - `BUSY` is expected at N+2.
  - Earliest next `req_ready` is in the first IDLE cycle after `BUSY` falls.
- Back-to-back frames: at least 4 cycles of arbiter overhead plus the `tx` frame length.
- `arb_busy` rises the cycle after accept and falls the cycle after `BUSY` falls.
- `start_err` and the `frame_cnt` increment are registered and visible the cycle after the triggering edge.

## Configuration
- `UART_ARB_RR_EN` defined:
  - Round-robin arbitration; search starts at the pointer, which is set to winner+1 (mod `NUM_REQ`) on each accept.
  - No requester holding valid waits more than `NUM_REQ`-1 frames.
- `UART_ARB_RR_EN` undefined:
  - Fixed priority; the lowest index wins.
  - The pointer logic is absent.

## Test plan
- Single request, even parity:
  - Stimulus: reset, then `req_valid`=0001, data0=0xAA, `cfg_par_en`=1, `cfg_par_typ`=0, `tx` attached.
  - Required response: `req_ready`=0001 for one edge; `DATA_VALID` pulse of exactly one cycle with `P_DATA`=0xAA, `PAR_EN`=1, `PAR_TYP`=0; `frame_cnt`=1 after `BUSY` falls.
- Contention with `UART_ARB_RR_EN`:
  - Stimulus: `req_valid`=1111 held, data i=0x10+i.
  - Required response: bytes are sent 0x10, 0x11, 0x12, 0x13, 0x10; `grant_id` sequence is 0, 1, 2, 3, 0.
- Contention without the macro:
  - Stimulus: same as above.
  - Required response: only 0x10 is sent while `req_valid`[0] stays 1; dropping it yields 0x11.
- Start timeout:
  - Stimulus: `BUSY` tied to 0, `START_TIMEOUT`=4.
  - Required response: `start_err` pulses 4 cycles after LOAD; FSM returns to IDLE; `frame_cnt` stays 0.
- Mid-frame reset:
  - Stimulus: assert `rst` in WAIT_DONE.
  - Required response: next cycle `arb_busy`=0, `P_DATA`=0x00, `frame_cnt`=0; `req_ready` stays 0 while `BUSY`=1.
- Configuration change after accept:
  - Stimulus: toggle `cfg_par_typ` during WAIT_DONE.
  - Required response: `PAR_TYP` output stays unchanged until the next accept.
